// File: rtl/exec_unit.sv
// rtl/exec_unit.sv - accumulator execute stage downstream of the CPU control unit
//
// Performs memory-reference (add, load, store, branch, isz) and register-reference
// (clr_ac, clr_e, comp_ac, load_ac, cir_r, cir_l, inc_ac) operations on AC/E,
// issues the data-memory transactions they need, and returns a one-cycle
// o_ex_done pulse plus PC redirect/skip indications to fetch.
//
// Optional feature: define EXEC_TIMEOUT_EN to abort a read that sees no
// i_mem_rvalid within RD_TIMEOUT cycles (sets the sticky o_err flag).
//
// Ports:
//   clk, reset_n                 clock (rising edge), async active-low reset
//   i_add .. i_isz               memory-reference strobes, level, held until done
//   i_clr_ac .. i_inc_ac         register-reference strobes, level
//   i_addr, i_imm                operand address, load_ac immediate
//   o_mem_addr/ce/we/wdata       data-memory request, ce is a one-cycle pulse
//   i_mem_rdata, i_mem_rvalid    read return
//   o_ac, o_e                    accumulator and extend flag
//   o_ex_done                    one-cycle completion pulse
//   o_pc_load, o_pc_target       branch redirect, valid with o_ex_done
//   o_pc_skip                    ISZ result was zero, valid with o_ex_done
//   o_err                        sticky read-timeout abort flag

module exec_unit #(
    parameter int DWIDTH     = 16,
    parameter int AWIDTH     = 12,
    parameter int RD_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_add,
    input  logic              i_load,
    input  logic              i_store,
    input  logic              i_branch,
    input  logic              i_isz,
    input  logic              i_clr_ac,
    input  logic              i_clr_e,
    input  logic              i_comp_ac,
    input  logic              i_load_ac,
    input  logic              i_cir_r,
    input  logic              i_cir_l,
    input  logic              i_inc_ac,
    input  logic [AWIDTH-1:0] i_addr,
    input  logic [7:0]        i_imm,
    output logic [AWIDTH-1:0] o_mem_addr,
    output logic              o_mem_ce,
    output logic              o_mem_we,
    output logic [DWIDTH-1:0] o_mem_wdata,
    input  logic [DWIDTH-1:0] i_mem_rdata,
    input  logic              i_mem_rvalid,
    output logic [DWIDTH-1:0] o_ac,
    output logic              o_e,
    output logic              o_ex_done,
    output logic              o_pc_load,
    output logic [AWIDTH-1:0] o_pc_target,
    output logic              o_pc_skip,
    output logic              o_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_WR,
        S_DONE,
        S_HOLD
    } state_t;

    // Which read-based operation is in flight.
    typedef enum logic [1:0] {
        K_ADD,
        K_LOAD,
        K_ISZ
    } rd_kind_t;

    localparam int              CNT_W    = $clog2(RD_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);

    state_t             state;
    rd_kind_t           rd_kind;
    logic               zero_flag;
    logic [CNT_W-1:0]   rd_cnt;

    logic               any_strobe;
    logic               any_reg_op;
    logic [DWIDTH:0]    add_sum;
    logic [DWIDTH-1:0]  rd_inc;

    assign any_reg_op = i_clr_ac | i_clr_e | i_comp_ac | i_load_ac
                      | i_cir_r  | i_cir_l | i_inc_ac;
    assign any_strobe = i_add | i_load | i_store | i_branch | i_isz | any_reg_op;

    // 17-bit sum so the carry out lands in E.
    assign add_sum = {1'b0, o_ac} + {1'b0, i_mem_rdata};
    assign rd_inc  = i_mem_rdata + {{(DWIDTH-1){1'b0}}, 1'b1};

`ifndef EXEC_TIMEOUT_EN
    assign o_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            rd_kind     <= K_ADD;
            zero_flag   <= 1'b0;
            rd_cnt      <= '0;
            o_mem_addr  <= '0;
            o_mem_ce    <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_wdata <= '0;
            o_ac        <= '0;
            o_e         <= 1'b0;
            o_ex_done   <= 1'b0;
            o_pc_load   <= 1'b0;
            o_pc_target <= '0;
            o_pc_skip   <= 1'b0;
`ifdef EXEC_TIMEOUT_EN
            o_err       <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    // Priority chain: only the highest-priority strobe is taken.
                    if (i_add) begin
                        rd_kind    <= K_ADD;
                        o_mem_addr <= i_addr;
                        o_mem_ce   <= 1'b1;
                        o_mem_we   <= 1'b0;
                        state      <= S_RD_REQ;
                    end else if (i_load) begin
                        rd_kind    <= K_LOAD;
                        o_mem_addr <= i_addr;
                        o_mem_ce   <= 1'b1;
                        o_mem_we   <= 1'b0;
                        state      <= S_RD_REQ;
                    end else if (i_store) begin
                        o_mem_addr  <= i_addr;
                        o_mem_ce    <= 1'b1;
                        o_mem_we    <= 1'b1;
                        o_mem_wdata <= o_ac;
                        zero_flag   <= 1'b0;
                        state       <= S_WR;
                    end else if (i_branch) begin
                        o_pc_target <= i_addr;
                        o_pc_load   <= 1'b1;
                        o_ex_done   <= 1'b1;
                        state       <= S_DONE;
                    end else if (i_isz) begin
                        rd_kind    <= K_ISZ;
                        o_mem_addr <= i_addr;
                        o_mem_ce   <= 1'b1;
                        o_mem_we   <= 1'b0;
                        state      <= S_RD_REQ;
                    end else if (any_reg_op) begin
                        o_ex_done <= 1'b1;
                        state     <= S_DONE;
                        if (i_clr_ac) begin
                            o_ac <= '0;
                        end else if (i_clr_e) begin
                            o_e <= 1'b0;
                        end else if (i_comp_ac) begin
                            o_ac <= ~o_ac;
                        end else if (i_load_ac) begin
                            o_ac <= {{(DWIDTH-8){1'b0}}, i_imm};
                        end else if (i_cir_r) begin
                            o_ac <= {o_e, o_ac[DWIDTH-1:1]};
                            o_e  <= o_ac[0];
                        end else if (i_cir_l) begin
                            o_ac <= {o_ac[DWIDTH-2:0], o_e};
                            o_e  <= o_ac[DWIDTH-1];
                        end else begin
                            o_ac <= o_ac + {{(DWIDTH-1){1'b0}}, 1'b1};
                        end
                    end
                end

                S_RD_REQ: begin
                    o_mem_ce <= 1'b0;
                    rd_cnt   <= '0;
                    state    <= S_RD_WAIT;
                end

                S_RD_WAIT: begin
                    if (i_mem_rvalid) begin
                        case (rd_kind)
                            K_ADD: begin
                                {o_e, o_ac} <= add_sum;
                                o_ex_done   <= 1'b1;
                                state       <= S_DONE;
                            end
                            K_LOAD: begin
                                o_ac      <= i_mem_rdata;
                                o_ex_done <= 1'b1;
                                state     <= S_DONE;
                            end
                            default: begin
                                // ISZ write-back of the incremented word.
                                o_mem_wdata <= rd_inc;
                                zero_flag   <= (rd_inc == '0);
                                o_mem_ce    <= 1'b1;
                                o_mem_we    <= 1'b1;
                                state       <= S_WR;
                            end
                        endcase
                    end else begin
`ifdef EXEC_TIMEOUT_EN
                        if (rd_cnt == CNT_LAST) begin
                            o_err     <= 1'b1;
                            o_ex_done <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            rd_cnt <= rd_cnt + 1'b1;
                        end
`else
                        // Counter saturates; it only triggers an abort when
                        // the timeout feature is compiled in.
                        if (rd_cnt != CNT_LAST) begin
                            rd_cnt <= rd_cnt + 1'b1;
                        end
`endif
                    end
                end

                S_WR: begin
                    o_mem_ce  <= 1'b0;
                    o_mem_we  <= 1'b0;
                    o_pc_skip <= zero_flag;
                    o_ex_done <= 1'b1;
                    state     <= S_DONE;
                end

                S_DONE: begin
                    o_ex_done <= 1'b0;
                    o_pc_load <= 1'b0;
                    o_pc_skip <= 1'b0;
                    // Strobes are level and still high if decode has not yet
                    // moved on; park in HOLD so they are not re-executed.
                    state     <= any_strobe ? S_HOLD : S_IDLE;
                end

                S_HOLD: begin
                    if (!any_strobe) begin
                        state <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exec_unit.sv
// tb/tb_exec_unit.sv - self-checking bench for exec_unit

module tb_exec_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [11:0] stb = '0;
    logic [11:0] i_addr = '0;
    logic [7:0]  i_imm = '0;
    logic [15:0] i_mem_rdata = '0;
    logic        i_mem_rvalid = 1'b0;
    logic [11:0] o_mem_addr;
    logic        o_mem_ce;
    logic        o_mem_we;
    logic [15:0] o_mem_wdata;
    logic [15:0] o_ac;
    logic        o_e;
    logic        o_ex_done;
    logic        o_pc_load;
    logic [11:0] o_pc_target;
    logic        o_pc_skip;
    logic        o_err;

    always #5 clk = ~clk;

    exec_unit dut (
        .clk(clk), .reset_n(reset_n),
        .i_add(stb[0]), .i_load(stb[1]), .i_store(stb[2]), .i_branch(stb[3]),
        .i_isz(stb[4]), .i_clr_ac(stb[5]), .i_clr_e(stb[6]), .i_comp_ac(stb[7]),
        .i_load_ac(stb[8]), .i_cir_r(stb[9]), .i_cir_l(stb[10]), .i_inc_ac(stb[11]),
        .i_addr(i_addr), .i_imm(i_imm),
        .o_mem_addr(o_mem_addr), .o_mem_ce(o_mem_ce), .o_mem_we(o_mem_we),
        .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata), .i_mem_rvalid(i_mem_rvalid),
        .o_ac(o_ac), .o_e(o_e), .o_ex_done(o_ex_done), .o_pc_load(o_pc_load),
        .o_pc_target(o_pc_target), .o_pc_skip(o_pc_skip), .o_err(o_err)
    );

`ifdef EXEC_TIMEOUT_EN
    localparam bit TO_ON = 1'b1;
`else
    localparam bit TO_ON = 1'b0;
`endif
    localparam int TO_LAT = 16;

    typedef struct {
        logic [11:0] a;
        logic        w;
        logic [15:0] d;
    } acc_t;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [15:0] mem [0:4095];
    acc_t        q[$];
    // Committed architectural state and the result expected at the next done.
    logic [15:0] m_ac = '0, p_ac = '0;
    logic        m_e = 1'b0, p_e = 1'b0;
    logic        m_err = 1'b0, p_err = 1'b0;
    logic        p_pcl = 1'b0, p_skip = 1'b0;
    logic [11:0] p_tgt = '0;
    logic        done_pend = 1'b0;
    logic [15:0] last_wdata = '0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (o_ex_done) begin
                chk("done_expected", 32'(done_pend), 32'd1);
                chk("ac_at_done", 32'(o_ac), 32'(p_ac));
                chk("e_at_done", 32'(o_e), 32'(p_e));
                chk("err_at_done", 32'(o_err), 32'(p_err));
                chk("pc_load", 32'(o_pc_load), 32'(p_pcl));
                if (p_pcl) chk("pc_target", 32'(o_pc_target), 32'(p_tgt));
                chk("pc_skip", 32'(o_pc_skip), 32'(p_skip));
                chk("accesses_left", 32'(q.size()), 32'd0);
                m_ac = p_ac; m_e = p_e; m_err = p_err; done_pend = 1'b0;
            end else begin
                chk("ac_steady", 32'(o_ac), 32'(m_ac));
                chk("e_steady", 32'(o_e), 32'(m_e));
                chk("err_steady", 32'(o_err), 32'(m_err));
                chk("pc_load_idle", 32'(o_pc_load), 32'd0);
                chk("pc_skip_idle", 32'(o_pc_skip), 32'd0);
            end
            if (o_mem_ce) begin
                chk("ce_expected", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) begin
                    acc_t x;
                    x = q.pop_front();
                    chk("mem_addr", 32'(o_mem_addr), 32'(x.a));
                    chk("mem_we", 32'(o_mem_we), 32'(x.w));
                    if (x.w) begin
                        chk("mem_wdata", 32'(o_mem_wdata), 32'(x.d));
                        last_wdata = o_mem_wdata;
                    end
                end
            end
        end
    end

    // Issue one operation; rdly = cycles from read ce to rvalid (0: never),
    // rst_at = loop cycle at which reset is asserted (-1: none).
    task automatic run_op(input logic [11:0] mask, input logic [11:0] addr,
                          input logic [7:0] imm, input int rdly, input int rst_at,
                          output int lat, output logic skip, output logic pcl,
                          output logic [11:0] tgt);
        int op, exp_lat, until_rv;
        bit done, aborted;
        logic [16:0] s;
        logic [15:0] rdv, v;
        op = 0;
        for (int i = 11; i >= 0; i--) if (mask[i]) op = i;
        rdv = mem[addr];
        p_ac = m_ac; p_e = m_e; p_err = m_err; p_pcl = 1'b0; p_skip = 1'b0; p_tgt = '0;
        exp_lat = 0;
        case (op)
            0, 1, 4: begin
                q.push_back('{addr, 1'b0, 16'h0});
                if (rdly == 0) begin
                    p_err = TO_ON; exp_lat = TO_LAT;
                end else if (op == 0) begin
                    s = {1'b0, m_ac} + {1'b0, rdv};
                    p_ac = s[15:0]; p_e = s[16]; exp_lat = rdly + 1;
                end else if (op == 1) begin
                    p_ac = rdv; exp_lat = rdly + 1;
                end else begin
                    v = rdv + 16'd1;
                    q.push_back('{addr, 1'b1, v});
                    mem[addr] = v; p_skip = (v == 16'h0); exp_lat = rdly + 2;
                end
            end
            2: begin
                q.push_back('{addr, 1'b1, m_ac}); mem[addr] = m_ac; exp_lat = 1;
            end
            3: begin p_pcl = 1'b1; p_tgt = addr; end
            5: p_ac = 16'h0;
            6: p_e = 1'b0;
            7: p_ac = ~m_ac;
            8: p_ac = {8'h00, imm};
            9: begin p_ac = {m_e, m_ac[15:1]}; p_e = m_ac[0]; end
            10: begin p_ac = {m_ac[14:0], m_e}; p_e = m_ac[15]; end
            default: p_ac = m_ac + 16'd1;
        endcase
        done_pend = 1'b1;
        stb = mask; i_addr = addr; i_imm = imm;
        until_rv = -1; done = 0; aborted = 0; lat = -1;
        skip = 1'b0; pcl = 1'b0; tgt = '0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(posedge clk); #1;
            if (c == 0) i_addr = ~addr;
            i_mem_rvalid = 1'b0;
            if (until_rv > 0) begin
                until_rv--;
                if (until_rv == 0) begin i_mem_rvalid = 1'b1; i_mem_rdata = rdv; end
            end
            if (o_mem_ce && !o_mem_we && rdly > 0) until_rv = rdly;
            if (o_ex_done) begin
                done = 1; lat = c; skip = o_pc_skip; pcl = o_pc_load; tgt = o_pc_target;
            end
            if (c == rst_at) begin
                #2 reset_n = 1'b0;
                #1;
                chk("reset_outputs_zero", 32'({o_ac, o_e, o_mem_ce, o_mem_we, o_ex_done,
                    o_pc_load, o_pc_skip, o_err} != '0 || o_mem_addr != '0 ||
                    o_mem_wdata != '0 || o_pc_target != '0), 32'd0);
                m_ac = '0; m_e = 1'b0; m_err = 1'b0; q.delete(); done_pend = 1'b0;
                stb = '0; i_mem_rvalid = 1'b0;
                @(posedge clk); #3 reset_n = 1'b1;
                @(posedge clk); #1;
                done = 1; aborted = 1;
            end
        end
        i_mem_rvalid = 1'b0;
        if (!aborted) begin
            chk("latency", 32'(lat), 32'(exp_lat));
            repeat (2) begin @(posedge clk); #1; end
            stb = '0;
            repeat (2) begin @(posedge clk); #1; end
        end else begin
            repeat (4) begin @(posedge clk); #1; end
        end
    endtask

    initial begin
        int lat;
        logic sk, pl;
        logic [11:0] tg;
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0;
        #12;
        chk("por_outputs_zero", 32'({o_ac, o_e, o_mem_ce, o_ex_done, o_pc_load,
            o_pc_skip, o_err} != '0), 32'd0);
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;

        run_op(12'h100, 12'h000, 8'h5A, 0, -1, lat, sk, pl, tg);
        chk("lit_load_ac", 32'(o_ac), 32'h005A);
        chk("lit_load_ac_lat", 32'(lat), 32'd0);

        run_op(12'h020, 12'h000, 8'h00, 0, -1, lat, sk, pl, tg);
        run_op(12'h080, 12'h000, 8'h00, 0, -1, lat, sk, pl, tg);
        chk("lit_comp_ffff", 32'(o_ac), 32'hFFFF);

        mem[12'h010] = 16'h0001;
        run_op(12'h001, 12'h010, 8'h00, 3, -1, lat, sk, pl, tg);
        chk("lit_add_ac", 32'(o_ac), 32'h0000);
        chk("lit_add_e", 32'(o_e), 32'd1);
        chk("lit_add_lat", 32'(lat), 32'd4);

        mem[12'h030] = 16'h1234;
        run_op(12'h002, 12'h030, 8'h00, 1, -1, lat, sk, pl, tg);
        chk("lit_load_mem", 32'(o_ac), 32'h1234);
        run_op(12'h004, 12'h0A0, 8'h00, 0, -1, lat, sk, pl, tg);
        chk("lit_store_wdata", 32'(last_wdata), 32'h1234);
        chk("lit_store_lat", 32'(lat), 32'd1);
        chk("lit_store_ac", 32'(o_ac), 32'h1234);

        mem[12'h020] = 16'hFFFF;
        run_op(12'h010, 12'h020, 8'h00, 2, -1, lat, sk, pl, tg);
        chk("lit_isz_skip1", 32'(sk), 32'd1);
        chk("lit_isz_wdata0", 32'(last_wdata), 32'h0000);
        mem[12'h020] = 16'h0005;
        run_op(12'h010, 12'h020, 8'h00, 1, -1, lat, sk, pl, tg);
        chk("lit_isz_skip0", 32'(sk), 32'd0);
        chk("lit_isz_wdata6", 32'(last_wdata), 32'h0006);
        chk("lit_isz_lat", 32'(lat), 32'd3);

        mem[12'h040] = 16'h8001;
        run_op(12'h002, 12'h040, 8'h00, 2, -1, lat, sk, pl, tg);
        run_op(12'h200, 12'h000, 8'h00, 0, -1, lat, sk, pl, tg);
        chk("lit_cir_r_ac", 32'(o_ac), 32'hC000);
        chk("lit_cir_r_e", 32'(o_e), 32'd1);
        run_op(12'h400, 12'h000, 8'h00, 0, -1, lat, sk, pl, tg);
        chk("lit_cir_l_ac", 32'(o_ac), 32'h8001);
        chk("lit_cir_l_e", 32'(o_e), 32'd1);
        run_op(12'h008, 12'h3FF, 8'h00, 0, -1, lat, sk, pl, tg);
        chk("lit_branch_load", 32'(pl), 32'd1);
        chk("lit_branch_target", 32'(tg), 32'h3FF);

        // All strobes at once: add must win.
        mem[12'h050] = 16'h7FFF;
        run_op(12'hFFF, 12'h050, 8'h00, 1, -1, lat, sk, pl, tg);
        chk("lit_prio_add_ac", 32'(o_ac), 32'h0000);
        chk("lit_prio_add_e", 32'(o_e), 32'd1);
        run_op(12'hAC0, 12'h000, 8'h00, 0, -1, lat, sk, pl, tg);
        chk("lit_prio_clr_e", 32'({o_ac, o_e}), 32'h0);
        run_op(12'h018, 12'h123, 8'h00, 1, -1, lat, sk, pl, tg);
        chk("lit_prio_branch", 32'({pl, tg}), 32'h1123);
        run_op(12'h080, 12'h000, 8'h00, 0, -1, lat, sk, pl, tg);
        run_op(12'h800, 12'h000, 8'h00, 0, -1, lat, sk, pl, tg);
        chk("lit_inc_wrap", 32'({o_e, o_ac}), 32'h0);
        run_op(12'h100, 12'h000, 8'h81, 0, -1, lat, sk, pl, tg);
        run_op(12'h200, 12'h000, 8'h00, 0, -1, lat, sk, pl, tg);
        chk("lit_cir_r_e0", 32'({o_e, o_ac}), 32'h10040);

        // Stray rvalid while idle must be ignored.
        i_mem_rvalid = 1'b1; i_mem_rdata = 16'hBEEF;
        @(posedge clk); #1;
        i_mem_rvalid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("lit_stray_rvalid", 32'(o_ac), 32'h0040);

        // Reset while waiting for read data.
        mem[12'h060] = 16'h1111;
        run_op(12'h001, 12'h060, 8'h00, 0, 3, lat, sk, pl, tg);
        chk("lit_after_reset_ac", 32'(o_ac), 32'h0000);

`ifdef EXEC_TIMEOUT_EN
        run_op(12'h100, 12'h000, 8'h33, 0, -1, lat, sk, pl, tg);
        run_op(12'h010, 12'h070, 8'h00, 0, -1, lat, sk, pl, tg);
        chk("lit_timeout_lat", 32'(lat), 32'd16);
        chk("lit_timeout_err", 32'(o_err), 32'd1);
        chk("lit_timeout_skip", 32'(sk), 32'd0);
        chk("lit_timeout_ac", 32'(o_ac), 32'h0033);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/exec_unit.md
Name: exec_unit

Overview:
- Accumulator execute stage that sits directly downstream of the CPU control unit.
- Consumes the one-hot operation strobes and operand address produced by decode, and performs the operation on AC/E.
- Issues the data-memory read/write transactions needed by memory-reference instructions.
- Returns a one-cycle ex_done pulse that lets the control unit leave its execute state.
- Also returns PC redirect (branch) and PC skip (ISZ) indications to the fetch logic.

Parameters:
- DWIDTH, 16, data/accumulator width.
- AWIDTH, 12, memory address width.
- RD_TIMEOUT, 15, maximum cycles in RD_WAIT before abort; used only with EXEC_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- i_add, i_load, i_store, i_branch, i_isz  in  1 each  memory-reference strobes, level, held until ex_done.
- i_clr_ac, i_clr_e, i_comp_ac, i_load_ac, i_cir_r, i_cir_l, i_inc_ac  in  1 each  register-reference strobes, level.
- i_addr  in  AWIDTH  operand address, valid while any memory-reference strobe is high.
- i_imm  in  8  immediate for load_ac (ir[7:0]).
- o_mem_addr  out  AWIDTH  memory address.
- o_mem_ce  out  1  memory chip enable, one-cycle pulse per access.
- o_mem_we  out  1  write enable; qualified by o_mem_ce.
- o_mem_wdata  out  DWIDTH  write data.
- i_mem_rdata  in  DWIDTH  read data, valid with i_mem_rvalid.
- i_mem_rvalid  in  1  read data valid, 1 or more cycles after a read ce.
- o_ac  out  DWIDTH  accumulator.
- o_e  out  1  carry/extend flag.
- o_ex_done  out  1  operation complete, one-cycle pulse.
- o_pc_load  out  1  branch taken, coincident with o_ex_done.
- o_pc_target  out  AWIDTH  branch target, valid with o_pc_load.
- o_pc_skip  out  1  ISZ result is zero, coincident with o_ex_done.
- o_err  out  1  sticky abort flag; driven 0 without EXEC_TIMEOUT_EN.

Behaviour:
- Reset (async, reset_n=0): state IDLE; AC, E, and all outputs 0. Reset mid-operation aborts with no further memory access; no done pulse.
- All outputs are registered.
- States: IDLE, RD_REQ, RD_WAIT, WR, DONE, HOLD.
- IDLE: accept when any strobe is high. If several are high, take only the highest priority, in this order: add > load > store > branch > isz > clr_ac > clr_e > comp_ac > load_ac > cir_r > cir_l > inc_ac.
- Register ops: update on the accept edge, then DONE. o_ex_done is high in the cycle after the accept edge (latency 1).
  - clr_ac: AC=0.
  - clr_e: E=0.
  - comp_ac: AC=~AC.
  - load_ac: AC={0, i_imm}.
  - cir_r: AC={E, AC[15:1]}, E=old AC[0].
  - cir_l: AC={AC[14:0], E}, E=old AC[15].
  - inc_ac: AC=AC+1 mod 2^16; E unchanged.
- add/load/isz:
  - RD_REQ drives o_mem_ce=1, o_mem_we=0, o_mem_addr=latched i_addr for exactly one cycle, then RD_WAIT.
  - On the edge where i_mem_rvalid=1, data M is captured.
  - add: {E,AC} = AC + M, 17-bit sum, so E = carry out.
  - load: AC=M; E unchanged.
  - Both then go to DONE.
  - isz: go to WR with wdata=M+1 mod 2^16; the zero flag is latched as (M+1==0).
- store: WR drives ce=1, we=1, addr=latched i_addr, wdata=AC for one cycle, then DONE.
- isz write-back uses the same WR cycle, then DONE; o_pc_skip=zero flag.
- branch: DONE directly; o_pc_load=1, o_pc_target=latched i_addr.
- i_addr is latched at accept; later changes are ignored.
- DONE: one cycle with o_ex_done=1 (plus o_pc_load/o_pc_skip if applicable). Next state is HOLD if any strobe is still high, else IDLE.
- HOLD: wait until all strobes are low, then IDLE. This prevents re-executing the same strobe.
- i_mem_rvalid outside RD_WAIT is ignored.
- Strobes changing mid-operation are ignored.

Optional Feature:
- Macro EXEC_TIMEOUT_EN.
- Defined: a counter runs in RD_WAIT. After RD_TIMEOUT cycles with no rvalid, go to DONE with AC/E unchanged, no write, o_pc_skip=0, and set o_err=1. o_err is sticky until reset.
- Undefined: RD_WAIT waits indefinitely; o_err is tied 0.

Test Plan:
- After reset, i_load_ac=1, i_imm=8'h5A → o_ex_done one cycle later; AC=16'h005A; HOLD until strobe drops; no mem access.
- AC=16'hFFFF, mem[12'h010]=16'h0001, i_add, i_addr=12'h010, rvalid 3 cycles after ce → single ce pulse, addr 12'h010; AC=16'h0000, E=1; done one cycle after rvalid edge.
- AC=16'h1234, i_store, i_addr=12'h0A0 → one cycle ce=1, we=1, wdata=16'h1234; done next cycle; AC unchanged.
- mem[12'h020]=16'hFFFF, i_isz → read, then write 16'h0000, done with o_pc_skip=1. Repeat with 16'h0005 → write 16'h0006, o_pc_skip=0.
- E=1, AC=16'h8001, i_cir_r → AC=16'hC000, E=1. Then i_cir_l → AC=16'h8001, E=1. Then i_branch, i_addr=12'h3FF → o_pc_load=1, o_pc_target=12'h3FF with done.
- Reset asserted in RD_WAIT → all outputs 0 immediately, no done. With EXEC_TIMEOUT_EN, no rvalid for 15 cycles → done, o_err=1, AC unchanged.
